// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream engine.
//   state_e   : FSM state encoding (IDLE=0, BUSY=1, HOLD=2)
//   CRC9_POLY : default generator x^9+x^8+x^5+x^4+x+1 without the x^9 term
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [8:0] CRC9_POLY = 9'h133;

endpackage

// File: rtl/crc_step_comb.sv
// Combinational CRC update: applies STEP data bits, MSB first, to crc_i.
// Non-reflected; the update for each bit is:
//   fb  = crc[CRC_W-1] ^ bit
//   crc = {crc[CRC_W-2:0], 0} ^ (fb ? POLY : 0)
// Ports:
//   crc_i  : running CRC before this step
//   data_i : STEP data bits, data_i[STEP-1] is applied first
//   crc_o  : CRC after all STEP bits
module crc_step_comb #(
  parameter int unsigned          CRC_W = 9,
  parameter logic [CRC_W-1:0]     POLY  = 9'h133,
  parameter int unsigned          STEP  = 16
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [STEP-1:0]  data_i,
  output logic [CRC_W-1:0] crc_o
);

  always_comb begin
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = crc_i;
    fb  = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      fb  = crc[CRC_W-1] ^ data_i[STEP-1-i];
      crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_o = crc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts frame words on a valid/ready stream, folds
// STEP bits per BUSY cycle into the running CRC, and presents one final CRC
// per frame on a valid/ready output.
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   in_valid / in_ready   : input word handshake
//   in_data               : input word, MSB processed first
//   in_first / in_last    : frame delimiters, qualified by in_valid
//   out_valid / out_ready : final CRC handshake
//   out_crc               : crc ^ XOROUT while out_valid, else 0
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W  = 9,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC9_POLY),
  parameter int unsigned      DATA_W = 16,
  parameter int unsigned      STEP   = 16,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc
);

  localparam int unsigned N    = DATA_W / STEP;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (STEP == 0 || (DATA_W % STEP) != 0) begin : g_bad_step
    $error("crc_stream_engine: DATA_W must be a non-zero multiple of STEP");
  end
  if (CRC_W < 2 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_stream_engine: CRC_W must be in 2..32");
  end

  state_e            state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [CRC_W-1:0]  crc_step;

  crc_step_comb #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .STEP  (STEP)
  ) u_step (
    .crc_i  (crc_q),
    .data_i (sreg_q[DATA_W-1 -: STEP]),
    .crc_o  (crc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      sreg_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_crc   = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          last_d  = in_last;
          // Without in_first the running CRC carries on from the previous word.
          if (in_first) crc_d = INIT;
          cnt_d   = CntW'(N - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        crc_d  = crc_step;
        sreg_d = sreg_q << STEP;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = last_q ? StHold : StIdle;
      end
      StHold: begin
        out_valid = 1'b1;
        out_crc   = crc_q ^ XOROUT;
        if (out_ready) begin
          // Reload so a following word without in_first starts a fresh frame.
          crc_d   = INIT;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
